// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int SERIAL_SUB_W_DEFAULT = 8;
endpackage

// File: rtl/serial_sub_if.sv
// Operand/result handshake bundle for serial_sub; the ovf signal exists only with SERIAL_SUB_OVF_EN.
interface serial_sub_if #(parameter int W = serial_sub_pkg::SERIAL_SUB_W_DEFAULT);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;

  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, diff, borrow, ovf);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, diff, borrow, ovf);
`else
  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, diff, borrow);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, diff, borrow);
`endif
endinterface

// File: rtl/serial_sub_full_sub.sv
// Combinational one-bit full subtractor: d = a - b - bi, bo = borrow out.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

// File: rtl/serial_sub.sv
// Bit-serial LSB-first subtractor diff = a - b behind valid/ready ports.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int W = SERIAL_SUB_W_DEFAULT
) (
  input logic       clk,
  input logic       rst_n,
  serial_sub_if.slave bus
);
  localparam int CNT_W = $clog2(W);

  state_t           state, state_nx;
  logic [W-1:0]     a_sh, b_sh, diff_q;
  logic [CNT_W-1:0] cnt;
  logic             bor, borrow_q;
  logic             d, bo;
  logic             in_ready, out_valid, accept, last;
`ifdef SERIAL_SUB_OVF_EN
  logic             sa, sb, ovf_q;
`endif

  full_sub u_full_sub (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .bi (bor),
    .d  (d),
    .bo (bo)
  );

  assign accept = bus.in_valid && in_ready;
  assign last   = (cnt == CNT_W'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nx = RUN;
      end
      RUN:  if (last) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Difference bits enter at the MSB so bit i settles at diff[i] after W shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      diff_q   <= '0;
      cnt      <= '0;
      bor      <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      sa       <= 1'b0;
      sb       <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else if (accept) begin
      a_sh <= bus.a;
      b_sh <= bus.b;
      cnt  <= '0;
      bor  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      sa   <= bus.a[W-1];
      sb   <= bus.b[W-1];
`endif
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      diff_q <= {d, diff_q[W-1:1]};
      bor    <= bo;
      cnt    <= cnt + 1'b1;
      if (last) begin
        borrow_q <= bo;
`ifdef SERIAL_SUB_OVF_EN
        // The final d is the result sign bit.
        ovf_q    <= (sa != sb) && (d != sa);
`endif
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: randomized and directed operand pairs against an arithmetic model.
module tb_serial_sub;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         br;
    logic         ov;
    int           acc;
  } exp_t;
  exp_t q[$];

  serial_sub_if #(.W(W)) bus ();

  serial_sub #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic fa, fb, fbi, fd, fbo;
  full_sub u_fs (.a(fa), .b(fb), .bi(fbi), .d(fd), .bo(fbo));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input int acc);
    exp_t e;
    int   sa, sb, r;
    e.d   = W'(int'(av) - int'(bv));
    e.br  = (av < bv);
    sa    = int'($signed(av));
    sb    = int'($signed(bv));
    r     = sa - sb;
    e.ov  = (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
    e.acc = acc;
    return e;
  endfunction

  // Monitor: checks every cycle the DUT presents a result, pops on handshake.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out actual diff=%0h required no output", bus.diff);
      end else begin
        if (!prev_ov) check("latency", cyc, q[0].acc + 1 + W);
        check("diff", bus.diff, q[0].d);
        check("borrow", bus.borrow, q[0].br);
        check("in_ready_done", bus.in_ready, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", bus.ovf, q[0].ov);
`endif
        if (bus.out_ready) void'(q.pop_front());
      end
    end
    prev_ov = bus.out_valid;
  end

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input bit hold, input int rdy_dly);
    int n;
    @(posedge clk); #1;
    bus.a = av;
    bus.b = bv;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 50) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual in_ready=0 required 1");
      bus.in_valid = 1'b0;
      return;
    end
    q.push_back(model(av, bv, cyc));
    @(posedge clk); #1;
    if (!hold) bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < W + 10) begin
      if (hold) begin
        bus.a = W'($urandom);
        bus.b = W'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (n == W + 10) begin
      checks++; errors++;
      $display("FAIL result_timeout actual out_valid=0 required 1");
      q.delete();
      return;
    end
    repeat (rdy_dly) begin @(posedge clk); #1; end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("idle_in_ready", bus.in_ready, 1'b1);
    check("idle_out_valid", bus.out_valid, 1'b0);
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_diff", bus.diff, '0);
    check("rst_borrow", bus.borrow, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", bus.ovf, 1'b0);
`endif
  endtask

  initial begin
    int r;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      {fa, fb, fbi} = 3'(i);
      #1;
      r = int'(fa) - int'(fb) - int'(fbi);
      check("fs_d", fd, r & 1);
      check("fs_bo", fbo, r < 0);
    end

    send(8'd5, 8'd3, 1'b0, 0);
    send(8'd3, 8'd5, 1'b0, 0);
    send(8'h00, 8'h01, 1'b0, 1);
    send(8'hA5, 8'hA5, 1'b0, 0);
    send(8'h5A, 8'h21, 1'b0, 5);
    send(8'hC3, 8'h3C, 1'b1, 0);
    send(8'h80, 8'h01, 1'b0, 0);
    send(8'h7F, 8'hFF, 1'b1, 2);
    send(8'h05, 8'h03, 1'b0, 0);
    send(8'hFF, 8'h00, 1'b0, 0);

    // Abort a transaction after four shifts.
    @(posedge clk); #1;
    bus.a = 8'h3C;
    bus.b = 8'hC3;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check_reset_values();
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(8'd9, 8'd2, 1'b0, 0);

    for (int i = 0; i < 30; i++)
      send(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    @(posedge clk); #1;
    check("drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual running required finished");
    $fatal(1, "timeout");
  end
endmodule
